// File: rtl/axi_dma_burst_merger.sv
// rtl/axi_dma_burst_merger.sv - merges AXI B responses of AW bursts into one completion per 1D transfer
module axi_dma_burst_merger #(
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [ID_WIDTH-1:0]  aw_id_i,
  input  logic                 aw_last_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [ID_WIDTH-1:0]  b_id_i,
  input  logic [1:0]           b_resp_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [ID_WIDTH-1:0]  done_id_o,
  output logic [1:0]           done_resp_o,
  output logic [CNT_WIDTH-1:0] done_bursts_o,
  output logic                 done_id_err_o,
  output logic                 busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [ID_WIDTH-1:0]  id_mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  id_mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem_q, last_mem_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [1:0]           acc_resp_q, acc_resp_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic                 acc_iderr_q, acc_iderr_d;

  logic                 done_valid_q, done_valid_d;
  logic [ID_WIDTH-1:0]  done_id_q, done_id_d;
  logic [1:0]           done_resp_q, done_resp_d;
  logic [CNT_WIDTH-1:0] done_bursts_q, done_bursts_d;
  logic                 done_iderr_q, done_iderr_d;

  logic                 empty, push, pop, head_last, id_mismatch;
  logic [ID_WIDTH-1:0]  head_id;
  logic [1:0]           merged_resp;
  logic [CNT_WIDTH-1:0] merged_cnt;

  // EXOKAY carries no extra severity, so fold it onto OKAY before comparing
  function automatic logic [1:0] norm_resp(input logic [1:0] r);
    return r[1] ? r : 2'b00;
  endfunction

  // After folding, numeric order of 00/10/11 equals severity order
  function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na, nb;
    na = norm_resp(a);
    nb = norm_resp(b);
    return (nb > na) ? nb : na;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign head_id     = id_mem_q[rd_ptr_q];
  assign head_last   = last_mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign aw_ready_o  = (count_q != FULL_CNT);
  // A closing B may only enter when the completion slot is free or being freed now
  assign b_ready_o   = !empty && (!head_last || !done_valid_q || done_ready_i);
  assign push        = aw_valid_i && aw_ready_o;
  assign pop         = b_valid_i && b_ready_o;
  assign id_mismatch = (b_id_i != head_id);
  assign merged_resp = worse_resp(acc_resp_q, b_resp_i);
  assign merged_cnt  = sat_inc(acc_cnt_q);

  assign done_valid_o  = done_valid_q;
  assign done_id_o     = done_id_q;
  assign done_resp_o   = done_resp_q;
  assign done_bursts_o = done_bursts_q;
  assign done_id_err_o = done_iderr_q;
  assign busy_o        = !empty || (acc_resp_q != 2'b00) || (acc_cnt_q != '0) || acc_iderr_q || done_valid_q;

  // Descriptor FIFO: write on push, advance read on pop, track occupancy
  always_comb begin
    id_mem_d   = id_mem_q;
    last_mem_d = last_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      id_mem_d[wr_ptr_q]   = aw_id_i;
      last_mem_d[wr_ptr_q] = aw_last_i;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Accumulate non-final bursts; a final burst moves the merged result into the completion register
  always_comb begin
    acc_resp_d    = acc_resp_q;
    acc_cnt_d     = acc_cnt_q;
    acc_iderr_d   = acc_iderr_q;
    done_valid_d  = done_valid_q;
    done_id_d     = done_id_q;
    done_resp_d   = done_resp_q;
    done_bursts_d = done_bursts_q;
    done_iderr_d  = done_iderr_q;
    if (done_valid_q && done_ready_i) begin
      done_valid_d  = 1'b0;
      done_id_d     = '0;
      done_resp_d   = 2'b00;
      done_bursts_d = '0;
      done_iderr_d  = 1'b0;
    end
    if (pop) begin
      if (head_last) begin
        done_valid_d  = 1'b1;
        done_id_d     = head_id;
        done_resp_d   = merged_resp;
        done_bursts_d = merged_cnt;
        done_iderr_d  = acc_iderr_q | id_mismatch;
        acc_resp_d    = 2'b00;
        acc_cnt_d     = '0;
        acc_iderr_d   = 1'b0;
      end else begin
        acc_resp_d  = merged_resp;
        acc_cnt_d   = merged_cnt;
        acc_iderr_d = acc_iderr_q | id_mismatch;
      end
    end
  end

  // State registers; reset drops queued descriptors, partial merges and pending completions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) id_mem_q[i] <= '0;
      last_mem_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      acc_resp_q    <= 2'b00;
      acc_cnt_q     <= '0;
      acc_iderr_q   <= 1'b0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      done_resp_q   <= 2'b00;
      done_bursts_q <= '0;
      done_iderr_q  <= 1'b0;
    end else begin
      id_mem_q      <= id_mem_d;
      last_mem_q    <= last_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      acc_resp_q    <= acc_resp_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_iderr_q   <= acc_iderr_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_resp_q   <= done_resp_d;
      done_bursts_q <= done_bursts_d;
      done_iderr_q  <= done_iderr_d;
    end
  end

endmodule

// File: tb/tb_axi_dma_burst_merger.sv
// tb/tb_axi_dma_burst_merger.sv - self-checking bench for axi_dma_burst_merger
module tb_axi_dma_burst_merger;

  localparam int IDW  = 4;
  localparam int DEP  = 8;
  localparam int CNTW = 3;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            aw_valid_i, aw_last_i, b_valid_i, done_ready_i;
  logic [IDW-1:0]  aw_id_i, b_id_i;
  logic [1:0]      b_resp_i;
  logic            aw_ready_o, b_ready_o, done_valid_o, done_id_err_o, busy_o;
  logic [IDW-1:0]  done_id_o;
  logic [1:0]      done_resp_o;
  logic [CNTW-1:0] done_bursts_o;

  axi_dma_burst_merger #(.ID_WIDTH(IDW), .FIFO_DEPTH(DEP), .CNT_WIDTH(CNTW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_last_i(aw_last_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_id_o(done_id_o),
    .done_resp_o(done_resp_o), .done_bursts_o(done_bursts_o), .done_id_err_o(done_id_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of descriptors, severity ranks, pending completion
  typedef struct { logic [IDW-1:0] id; logic last; } desc_t;
  desc_t mq[$];
  int    m_acc_sev, m_acc_cnt, m_dsev, m_dcnt;
  bit    m_acc_err, m_pend, m_derr;
  logic [IDW-1:0] m_did;

  // Values sampled in the most recent step, and last accepted completion
  logic s_aw_ready, s_b_ready, s_done_valid;
  logic [1:0] s_done_resp;
  logic [IDW-1:0] s_done_id;
  bit cap;
  logic [IDW-1:0] cap_id;
  logic [1:0] cap_resp;
  logic [CNTW-1:0] cap_bursts;
  logic cap_err;

  function automatic int sev(input logic [1:0] r);
    if (r == 2'b11) return 2;
    if (r == 2'b10) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] sev2resp(input int s);
    if (s == 2) return 2'b11;
    if (s == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_acc_sev = 0; m_acc_cnt = 0; m_acc_err = 0;
    m_pend = 0; m_dsev = 0; m_dcnt = 0; m_derr = 0; m_did = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    aw_valid_i = 0; aw_id_i = '0; aw_last_i = 0;
    b_valid_i = 0; b_id_i = '0; b_resp_i = 2'b00; done_ready_i = 0;
    @(posedge clk_i);
    model_clear();
    #1;
    rst_i = 1'b0;
    chk("rst_done_valid", done_valid_o, 0);
    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_bursts", done_bursts_o, 0);
  endtask

  task automatic step(input bit awv, input logic [IDW-1:0] awid, input bit awl,
                      input bit bv, input logic [IDW-1:0] bid, input logic [1:0] br, input bit dr);
    bit e_awr, e_br, push, pop, dhs, busy_e;
    desc_t h;
    @(negedge clk_i);
    aw_valid_i = awv; aw_id_i = awid; aw_last_i = awl;
    b_valid_i = bv; b_id_i = bid; b_resp_i = br; done_ready_i = dr;
    #1;
    e_awr  = mq.size() < DEP;
    e_br   = (mq.size() > 0) && (!mq[0].last || !m_pend || dr);
    busy_e = (mq.size() > 0) || m_acc_sev != 0 || m_acc_cnt != 0 || m_acc_err || m_pend;
    s_aw_ready = aw_ready_o; s_b_ready = b_ready_o; s_done_valid = done_valid_o;
    s_done_resp = done_resp_o; s_done_id = done_id_o;
    chk("aw_ready", aw_ready_o, e_awr);
    chk("b_ready", b_ready_o, e_br);
    chk("done_valid", done_valid_o, m_pend);
    chk("busy", busy_o, busy_e);
    if (m_pend) begin
      chk("done_id", done_id_o, m_did);
      chk("done_resp", done_resp_o, sev2resp(m_dsev));
      chk("done_bursts", done_bursts_o, m_dcnt);
      chk("done_id_err", done_id_err_o, m_derr);
    end
    if (done_valid_o && dr) begin
      cap = 1; cap_id = done_id_o; cap_resp = done_resp_o;
      cap_bursts = done_bursts_o; cap_err = done_id_err_o;
    end
    push = awv && e_awr;
    pop  = bv && e_br;
    dhs  = m_pend && dr;
    @(posedge clk_i);
    if (dhs) m_pend = 0;
    if (pop) begin
      h = mq.pop_front();
      if (sev(br) > m_acc_sev) m_acc_sev = sev(br);
      m_acc_cnt = (m_acc_cnt + 1 > MAXC) ? MAXC : m_acc_cnt + 1;
      if (bid != h.id) m_acc_err = 1;
      if (h.last) begin
        m_pend = 1; m_did = h.id; m_dsev = m_acc_sev; m_dcnt = m_acc_cnt; m_derr = m_acc_err;
        m_acc_sev = 0; m_acc_cnt = 0; m_acc_err = 0;
      end
    end
    if (push) mq.push_back('{id: awid, last: awl});
  endtask

  task automatic idle_until_cap();
    for (int k = 0; k < 6 && !cap; k++) step(0, '0, 0, 0, '0, 2'b00, 1);
    chk("done_seen", cap, 1);
  endtask

  task automatic drain();
    logic [IDW-1:0] hid;
    for (int k = 0; k < 40; k++) begin
      if (mq.size() == 0 && !m_pend) break;
      hid = (mq.size() > 0) ? mq[0].id : '0;
      step(0, '0, 0, mq.size() > 0, hid, 2'b00, 1);
    end
    chk("drained", (mq.size() == 0 && !m_pend), 1);
  endtask

  typedef struct {
    int             n;
    logic [IDW-1:0] id;
    logic [IDW-1:0] bid;
    logic [3:0][1:0] resps;
    logic [1:0]     exp_resp;
    int             exp_bursts;
    logic           exp_iderr;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{n: 3, id: 4'd3,  bid: 4'd3,  resps: {2'b00, 2'b00, 2'b10, 2'b00}, exp_resp: 2'b10, exp_bursts: 3, exp_iderr: 1'b0};
    tbl[1] = '{n: 3, id: 4'd6,  bid: 4'd6,  resps: {2'b00, 2'b10, 2'b11, 2'b01}, exp_resp: 2'b11, exp_bursts: 3, exp_iderr: 1'b0};
    tbl[2] = '{n: 1, id: 4'd1,  bid: 4'd1,  resps: {2'b00, 2'b00, 2'b00, 2'b01}, exp_resp: 2'b00, exp_bursts: 1, exp_iderr: 1'b0};
    tbl[3] = '{n: 1, id: 4'd4,  bid: 4'd5,  resps: {2'b00, 2'b00, 2'b00, 2'b00}, exp_resp: 2'b00, exp_bursts: 1, exp_iderr: 1'b1};
    tbl[4] = '{n: 4, id: 4'd2,  bid: 4'd2,  resps: {2'b00, 2'b00, 2'b01, 2'b10}, exp_resp: 2'b10, exp_bursts: 4, exp_iderr: 1'b0};
    tbl[5] = '{n: 2, id: 4'd15, bid: 4'd15, resps: {2'b00, 2'b00, 2'b11, 2'b11}, exp_resp: 2'b11, exp_bursts: 2, exp_iderr: 1'b0};

    rst_i = 1'b1;
    aw_valid_i = 0; aw_id_i = '0; aw_last_i = 0;
    b_valid_i = 0; b_id_i = '0; b_resp_i = 2'b00; done_ready_i = 0;
    model_clear();
    do_reset();

    // Table-driven transfers
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < tbl[t].n; j++) step(1, tbl[t].id, j == tbl[t].n - 1, 0, '0, 2'b00, 1);
      cap = 0;
      for (int j = 0; j < tbl[t].n; j++) step(0, '0, 0, 1, tbl[t].bid, tbl[t].resps[j], 1);
      idle_until_cap();
      chk("tbl_id", cap_id, tbl[t].id);
      chk("tbl_resp", cap_resp, tbl[t].exp_resp);
      chk("tbl_bursts", cap_bursts, tbl[t].exp_bursts);
      chk("tbl_iderr", cap_err, tbl[t].exp_iderr);
      step(0, '0, 0, 0, '0, 2'b00, 1);
      chk("tbl_busy_after", busy_o, 0);
    end

    // Fill to full, then pop at full and push+pop below full
    do_reset();
    for (int i = 0; i < DEP; i++) step(1, 4'(i), 1, 0, '0, 2'b00, 1);
    step(1, 4'd9, 1, 0, '0, 2'b00, 1);
    chk("full_aw_ready", s_aw_ready, 0);
    step(1, 4'd9, 1, 1, 4'd0, 2'b00, 1);
    chk("full_pop_aw_ready", s_aw_ready, 0);
    step(1, 4'd10, 1, 1, 4'd1, 2'b00, 1);
    chk("pushpop_aw_ready", s_aw_ready, 1);
    step(0, '0, 0, 0, '0, 2'b00, 1);
    chk("pushpop_count_kept", s_aw_ready, 1);
    drain();

    // Completion backpressure stalls the next closing B
    do_reset();
    step(1, 4'd7, 1, 0, '0, 2'b00, 0);
    step(1, 4'd8, 1, 0, '0, 2'b00, 0);
    step(0, '0, 0, 1, 4'd7, 2'b10, 0);
    step(0, '0, 0, 1, 4'd8, 2'b00, 0);
    chk("bp_stall_b_ready", s_b_ready, 0);
    chk("bp_done_valid", s_done_valid, 1);
    chk("bp_resp", s_done_resp, 2'b10);
    step(0, '0, 0, 1, 4'd8, 2'b00, 0);
    chk("bp_resp_held", s_done_resp, 2'b10);
    step(0, '0, 0, 1, 4'd8, 2'b00, 1);
    chk("bp_release_b_ready", s_b_ready, 1);
    step(0, '0, 0, 0, '0, 2'b00, 0);
    chk("bp_second_valid", s_done_valid, 1);
    chk("bp_second_id", s_done_id, 4'd8);
    drain();

    // b_ready rises one cycle after the first push
    do_reset();
    step(1, 4'd4, 1, 1, 4'd4, 2'b00, 1);
    chk("empty_b_ready", s_b_ready, 0);
    step(0, '0, 0, 1, 4'd4, 2'b00, 1);
    chk("next_b_ready", s_b_ready, 1);
    drain();

    // Counter saturation: 10-burst transfer with a 3-bit counter
    do_reset();
    cap = 0;
    for (int i = 0; i < 10; i++) step(1, 4'd5, i == 9, i > 0, 4'd5, 2'b00, 1);
    step(0, '0, 0, 1, 4'd5, 2'b01, 1);
    idle_until_cap();
    chk("sat_bursts", cap_bursts, MAXC);
    chk("sat_resp", cap_resp, 2'b00);

    // Reset in the middle of a transfer
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 4'd9, i == 3, 0, '0, 2'b00, 1);
    step(0, '0, 0, 1, 4'd9, 2'b10, 1);
    step(0, '0, 0, 1, 4'd9, 2'b00, 1);
    do_reset();
    cap = 0;
    step(1, 4'd2, 1, 0, '0, 2'b00, 1);
    step(0, '0, 0, 1, 4'd2, 2'b00, 1);
    idle_until_cap();
    chk("post_rst_bursts", cap_bursts, 1);
    chk("post_rst_resp", cap_resp, 2'b00);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [IDW-1:0] rid, bid;
      rid = 4'($urandom);
      bid = (mq.size() > 0) ? mq[0].id : 4'($urandom);
      if ($urandom_range(0, 7) == 0) bid = bid ^ 4'd1;
      step($urandom_range(0, 1) == 1, rid, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, bid, 2'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
